// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM write-back arbiter.
// Also used by the DRAM_ARB_STATS_EN build (stat counter width).
package dram_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int STAT_WIDTH = 32;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_writeback_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
module rr_pick
    import dram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int  j;
        logic found;
        j     = 0;
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dram_writeback_arbiter.sv
// Burst-locked round-robin arbiter sharing one registered DRAM write channel.
// Define DRAM_ARB_STATS_EN to add per-requester beat and stall counters.
module dram_writeback_arbiter
    import dram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 16,
    parameter  int GRAD_WIDTH = 16,
    parameter  int BURST_MAX  = 16,
    localparam int IW         = idx_width(NUM_REQ),
    localparam int CW         = $clog2(BURST_MAX + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_address,
    input  logic [NUM_REQ*GRAD_WIDTH-1:0]  req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ADDR_WIDTH-1:0]          dram_address,
    output logic signed [GRAD_WIDTH-1:0]   dram_value,
    output logic                           dram_valid,
    input  logic                           dram_ready,
    output logic [IW-1:0]                  dram_src_id,
    output logic                           arb_busy,
    output logic [IW-1:0]                  arb_owner
`ifdef DRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0]  stat_beats,
    output logic [STAT_WIDTH-1:0]          stat_stall
`endif
);

    arb_state_t          state, state_n;
    logic [IW-1:0]       rr_ptr, rr_ptr_n, owner_n, sel, pick_idx, owner_inc, pick_inc;
    logic [CW-1:0]       beat_cnt, beat_cnt_n;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                slot_free, accept;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign slot_free = !dram_valid || dram_ready;
    assign arb_busy  = (state == LOCKED);
    assign owner_inc = (arb_owner == IW'(NUM_REQ - 1)) ? '0 : arb_owner + 1'b1;
    assign pick_inc  = (pick_idx  == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        owner_n    = arb_owner;
        beat_cnt_n = beat_cnt;
        sel        = arb_owner;
        accept     = 1'b0;
        req_ready  = '0;
        unique case (state)
            IDLE: begin
                if (slot_free && |pick_grant) begin
                    accept     = 1'b1;
                    sel        = pick_idx;
                    req_ready  = pick_grant;
                    owner_n    = pick_idx;
                    beat_cnt_n = CW'(1);
                    if (BURST_MAX == 1) rr_ptr_n = pick_inc;
                    else                state_n  = LOCKED;
                end
            end
            LOCKED: begin
                // Owner dropping valid forfeits the rest of its burst.
                if (slot_free) begin
                    if (req_valid[arb_owner]) begin
                        accept               = 1'b1;
                        req_ready[arb_owner] = 1'b1;
                        beat_cnt_n           = beat_cnt + 1'b1;
                        if (beat_cnt == CW'(BURST_MAX - 1)) begin
                            state_n  = IDLE;
                            rr_ptr_n = owner_inc;
                        end
                    end else begin
                        state_n  = IDLE;
                        rr_ptr_n = owner_inc;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            arb_owner <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_ptr_n;
            arb_owner <= owner_n;
            beat_cnt  <= beat_cnt_n;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dram_valid   <= 1'b0;
            dram_address <= '0;
            dram_value   <= '0;
            dram_src_id  <= '0;
        end else if (slot_free) begin
            dram_valid <= accept;
            if (accept) begin
                dram_address <= req_address[sel*ADDR_WIDTH +: ADDR_WIDTH];
                dram_value   <= req_value[sel*GRAD_WIDTH +: GRAD_WIDTH];
                dram_src_id  <= sel;
            end
        end
    end

`ifdef DRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_WIDTH-1:0] beats_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beats_q    <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && beats_q[i] != '1) beats_q[i] <= beats_q[i] + 1'b1;
            if (dram_valid && !dram_ready && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
        end
    end

    assign stat_beats = beats_q;
`endif

endmodule

// File: tb/tb_dram_writeback_arbiter.sv
// Scoreboard bench: reference arbiter model predicts grants and beats; monitor checks DRAM side.
// Covers the DRAM_ARB_STATS_EN counters when that macro is defined.
module tb_dram_writeback_arbiter;

    localparam int N  = 4;
    localparam int BM = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*16-1:0] req_address;
    logic [N*16-1:0] req_value;
    logic [N-1:0]    req_ready;
    logic [15:0]     dram_address;
    logic [15:0]     dram_value;
    logic            dram_valid;
    logic            dram_ready;
    logic [1:0]      dram_src_id;
    logic            arb_busy;
    logic [1:0]      arb_owner;
`ifdef DRAM_ARB_STATS_EN
    logic [N*32-1:0] stat_beats;
    logic [31:0]     stat_stall;
`endif

    dram_writeback_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(16), .GRAD_WIDTH(16), .BURST_MAX(BM)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_address  (req_address),
        .req_value    (req_value),
        .req_ready    (req_ready),
        .dram_address (dram_address),
        .dram_value   (dram_value),
        .dram_valid   (dram_valid),
        .dram_ready   (dram_ready),
        .dram_src_id  (dram_src_id),
        .arb_busy     (arb_busy),
        .arb_owner    (arb_owner)
`ifdef DRAM_ARB_STATS_EN
        ,
        .stat_beats   (stat_beats),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] val;
        logic [1:0]  id;
    } beat_t;

    beat_t       sq[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference model state: owner < 0 means nobody holds the channel.
    int          m_owner, m_last, m_ptr, m_cnt, m_stall;
    int          m_beats[N];
    bit          m_valid;
    logic [11:0] seq[N];
    logic [15:0] hval[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0; m_valid = 0; m_stall = 0;
        for (int i = 0; i < N; i++) m_beats[i] = 0;
        sq.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #4 reset = 1'b1;
        #1;
        chk("rst_dram_valid", dram_valid, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_arb_owner", arb_owner, 0);
        chk("rst_dram_address", dram_address, 0);
        chk("rst_dram_value", dram_value, 0);
        chk("rst_dram_src_id", dram_src_id, 0);
        model_reset();
    endtask

    task automatic cycle(input logic [N-1:0] v, input logic rdy);
        int            g;
        bit            sf;
        logic [N-1:0]  exp_rdy;
        beat_t         b;
        @(negedge clock);
        reset      = 1'b0;
        req_valid  = v;
        dram_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_address[i*16 +: 16] = {i[3:0], seq[i]};
            req_value[i*16 +: 16]   = hval[i];
        end
        #2;
        chk("dram_valid", dram_valid, m_valid);
        chk("arb_busy", arb_busy, m_owner >= 0);
        chk("arb_owner", arb_owner, m_last);
        if (m_valid && !rdy) m_stall++;
        sf = !m_valid || rdy;
        g  = -1;
        if (sf) begin
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end else if (v[m_owner]) g = m_owner;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (sf) begin
            if (m_owner < 0) begin
                if (g >= 0) begin
                    m_cnt = 1; m_last = g;
                    if (BM == 1) m_ptr = (g + 1) % N;
                    else         m_owner = g;
                end
            end else if (g >= 0) begin
                m_cnt++;
                if (m_cnt == BM) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
            end else begin
                m_ptr = (m_owner + 1) % N; m_owner = -1;
            end
            m_valid = (g >= 0);
        end
        if (g >= 0) begin
            b.addr = {g[3:0], seq[g]};
            b.val  = hval[g];
            b.id   = g[1:0];
            sq.push_back(b);
            m_beats[g]++;
            seq[g]++;
            hval[g] = 16'($urandom);
        end
    endtask

    task automatic chk_stats();
        #5;
`ifdef DRAM_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("stat_beats", stat_beats[i*32 +: 32], m_beats[i]);
        chk("stat_stall", stat_stall, m_stall);
`endif
    endtask

    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset && dram_valid && dram_ready) begin
                if (sq.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    e = sq.pop_front();
                    chk("dram_address", dram_address, e.addr);
                    chk("dram_value", dram_value, e.val);
                    chk("dram_src_id", dram_src_id, e.id);
                end
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; req_valid = '0; req_address = '0; req_value = '0; dram_ready = 1'b0;
        for (int i = 0; i < N; i++) begin seq[i] = '0; hval[i] = 16'($urandom); end
        model_reset();

        // Single requester streaming through a burst boundary
        do_reset();
        seq[1] = 12'h100;
        for (int c = 0; c < 24; c++) cycle(4'b0010, 1'b1);

        // All requesters busy, then the output stalls for 7 cycles
        do_reset();
        for (int c = 0; c < 64; c++) cycle(4'b1111, 1'b1);
        for (int c = 0; c < 7; c++)  cycle(4'b0000, 1'b0);
        chk_stats();
        for (int c = 0; c < 3; c++)  cycle(4'b0000, 1'b1);

        // Owner 2 drops after 5 beats while 3 waits
        do_reset();
        for (int c = 0; c < 5; c++) cycle(4'b1100, 1'b1);
        cycle(4'b1000, 1'b1);
        chk("drop_release", req_ready, 4'b0000);
        cycle(4'b1000, 1'b1);
        chk("drop_regrant", req_ready, 4'b1000);
        for (int c = 0; c < 4; c++) cycle(4'b1000, 1'b1);

        // Backpressure mid-burst
        do_reset();
        for (int c = 0; c < 5; c++)  cycle(4'b0001, 1'b1);
        for (int c = 0; c < 7; c++)  cycle(4'b0001, 1'b0);
        for (int c = 0; c < 16; c++) cycle(4'b0001, 1'b1);

        // Randomised traffic and ready
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] v;
            for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < 70);
            cycle(v, $urandom_range(0, 99) < 75);
        end
        for (int c = 0; c < 3; c++) cycle(4'b0000, 1'b1);
        chk("random_drain", sq.size(), 0);

        // Async reset while owner 1 is at beat 9
        do_reset();
        guard = 0;
        while (!(m_owner == 1 && m_cnt == 9) && guard < 100) begin
            cycle(4'b1111, 1'b1);
            guard++;
        end
        chk("reach_owner1_beat9", guard < 100, 1);
        do_reset();
        cycle(4'b1111, 1'b1);
        chk("post_reset_grant", req_ready, 4'b0001);
        for (int c = 0; c < 20; c++) cycle(4'b1111, $urandom_range(0, 1));

        for (int c = 0; c < 4; c++) cycle(4'b0000, 1'b1);
        chk_stats();
        chk("final_drain", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
